// File: rtl/fios_issue_sequencer.sv
// Word-pair issue sequencer for a word-serial FIOS Montgomery multiplier: row-major (i, j) issue, quotient bubble after j = 0, pipeline drain.
// First issue one cycle after start; done after s*s + s*Q_LAT + PIPE_DEPTH + 1 cycles; stall_i freezes all state and gates en_o/valid_o.
module fios_issue_sequencer #(
  parameter int NWORDS_MAX = 16,
  parameter int Q_LAT      = 1,
  parameter int PIPE_DEPTH = 2,
  localparam int IDX_W = (NWORDS_MAX < 2) ? 1 : $clog2(NWORDS_MAX),
  localparam int LEN_W = $clog2(NWORDS_MAX + 1)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] nwords_i,
  input  logic             stall_i,
  output logic             busy_o,
  output logic             en_o,
  output logic             valid_o,
  output logic [IDX_W-1:0] a_idx_o,
  output logic [IDX_W-1:0] b_idx_o,
  output logic             first_o,
  output logic             last_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int QW = (Q_LAT < 1) ? 1 : $clog2(Q_LAT + 1);
  localparam int DW = (PIPE_DEPTH < 1) ? 1 : $clog2(PIPE_DEPTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_QWAIT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // With no pipeline to drain, completion follows the final issue directly.
  localparam state_t END_STATE = (PIPE_DEPTH > 0) ? ST_DRAIN : ST_DONE;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [LEN_W-1:0] s_q, s_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             fin_q, fin_d;

  logic [IDX_W-1:0] last_idx;
  logic             j_first;
  logic             j_last;
  logic             is_final;
  logic             s_bad;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      s_q     <= '0;
      qcnt_q  <= '0;
      dcnt_q  <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      s_q     <= s_d;
      qcnt_q  <= qcnt_d;
      dcnt_q  <= dcnt_d;
      fin_q   <= fin_d;
    end
  end

  // s_q is at most NWORDS_MAX while busy, so s_q-1 always fits the index width.
  assign last_idx = IDX_W'(s_q - LEN_W'(1));
  assign j_first  = (j_q == '0);
  assign j_last   = (j_q == last_idx);
  assign is_final = j_last && (i_q == last_idx);
  assign s_bad    = (nwords_i == '0) || (nwords_i > LEN_W'(NWORDS_MAX));

  assign a_idx_o = j_q;
  assign b_idx_o = i_q;
  assign first_o = valid_o & j_first;
  assign last_o  = valid_o & j_last;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    s_d     = s_q;
    qcnt_d  = qcnt_q;
    dcnt_d  = dcnt_q;
    fin_d   = fin_q;
    busy_o  = (state_q != ST_IDLE);
    en_o    = 1'b0;
    valid_o = 1'b0;
    done_o  = 1'b0;
    err_o   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (s_bad) begin
            err_o = 1'b1;
          end else begin
            s_d     = nwords_i;
            i_d     = '0;
            j_d     = '0;
            fin_d   = 1'b0;
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        if (!stall_i) begin
          en_o    = 1'b1;
          valid_o = 1'b1;
          if (j_last) begin
            j_d = '0;
            i_d = (i_q == last_idx) ? '0 : i_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
          fin_d = fin_q | is_final;
          if ((Q_LAT > 0) && j_first) begin
            state_d = ST_QWAIT;
            qcnt_d  = QW'(Q_LAT);
          end else if (is_final) begin
            state_d = END_STATE;
            dcnt_d  = DW'(PIPE_DEPTH);
          end
        end
      end

      ST_QWAIT: begin
        if (!stall_i) begin
          en_o   = 1'b1;
          qcnt_d = qcnt_q - 1'b1;
          if (qcnt_q == QW'(1)) begin
            if (fin_q) begin
              state_d = END_STATE;
              dcnt_d  = DW'(PIPE_DEPTH);
            end else begin
              state_d = ST_ISSUE;
            end
          end
        end
      end

      ST_DRAIN: begin
        if (!stall_i) begin
          en_o   = 1'b1;
          dcnt_d = dcnt_q - 1'b1;
          if (dcnt_q == DW'(1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fios_issue_sequencer.sv
// Directed bench: dut1 uses Q_LAT=1/PIPE_DEPTH=2, dut2 uses Q_LAT=0/PIPE_DEPTH=0; both NWORDS_MAX=16.
module tb_fios_issue_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic [4:0] nwords = '0;
  logic       stall = 1'b0;

  logic       busy1, en1, valid1, first1, last1, done1, err1;
  logic [3:0] a1, b1;
  logic       busy2, en2, valid2, first2, last2, done2, err2;
  logic [3:0] a2, b2;

  always #5 clk = ~clk;

  fios_issue_sequencer #(.NWORDS_MAX(16), .Q_LAT(1), .PIPE_DEPTH(2)) dut1 (
    .clock_i(clk), .reset_i(rst_n), .start_i(start1), .nwords_i(nwords), .stall_i(stall),
    .busy_o(busy1), .en_o(en1), .valid_o(valid1), .a_idx_o(a1), .b_idx_o(b1),
    .first_o(first1), .last_o(last1), .done_o(done1), .err_o(err1)
  );

  fios_issue_sequencer #(.NWORDS_MAX(16), .Q_LAT(0), .PIPE_DEPTH(0)) dut2 (
    .clock_i(clk), .reset_i(rst_n), .start_i(start2), .nwords_i(nwords), .stall_i(stall),
    .busy_o(busy2), .en_o(en2), .valid_o(valid2), .a_idx_o(a2), .b_idx_o(b2),
    .first_o(first2), .last_o(last2), .done_o(done2), .err_o(err2)
  );

  int checks = 0;
  int passed = 0;

  // Per-cycle capture of the selected DUT, bit c = cycle c after the start edge.
  bit          sel2 = 1'b0;
  logic [31:0] vm, em, dm, fm, lm, bm, errm;
  logic [127:0] idxs;
  int          nv;
  logic [7:0]  idx_at [0:31];

  task automatic run_capture(input bit d2, input logic [4:0] s, input int ncyc,
                             input logic [31:0] stall_m, input logic [31:0] strt_m,
                             input logic [4:0] mid_nw);
    sel2 = d2;
    vm = '0; em = '0; dm = '0; fm = '0; lm = '0; bm = '0; errm = '0; idxs = '0; nv = 0;
    @(posedge clk); #1;
    if (d2) start2 = 1'b1; else start1 = 1'b1;
    nwords = s;
    stall = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
        if (strt_m[c]) begin
          if (d2) start2 = 1'b1; else start1 = 1'b1;
          nwords = mid_nw;
        end
        stall = stall_m[c];
      end
      @(negedge clk);
      vm[c]   = sel2 ? valid2 : valid1;
      em[c]   = sel2 ? en2    : en1;
      dm[c]   = sel2 ? done2  : done1;
      fm[c]   = sel2 ? first2 : first1;
      lm[c]   = sel2 ? last2  : last1;
      bm[c]   = sel2 ? busy2  : busy1;
      errm[c] = sel2 ? err2   : err1;
      idx_at[c] = sel2 ? {b2, a2} : {b1, a1};
      if (vm[c]) begin
        idxs = {idxs[119:0], idx_at[c]};
        nv++;
      end
    end
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] o;
    #3;
    o = {busy1, en1, valid1, first1, last1, done1, err1, a1, b1[0]};
    checks++;
    if (o !== 12'h000 || b1 !== 4'h0) $display("FAIL reset_outputs got %h/%h exp 000/0", o, b1);
    else passed++;
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_s2_nominal();
    run_capture(1'b0, 5'd2, 12, 32'h0, 32'h0, 5'd0);
    checks++; if (vm !== 32'h5A)  $display("FAIL s2_valid got %h exp %h", vm, 32'h5A);  else passed++;
    checks++; if (em !== 32'h1FE) $display("FAIL s2_en got %h exp %h", em, 32'h1FE);   else passed++;
    checks++; if (dm !== 32'h200) $display("FAIL s2_done got %h exp %h", dm, 32'h200); else passed++;
    checks++; if (bm !== 32'h3FE) $display("FAIL s2_busy got %h exp %h", bm, 32'h3FE); else passed++;
    checks++; if (fm !== 32'h12)  $display("FAIL s2_first got %h exp %h", fm, 32'h12);  else passed++;
    checks++; if (lm !== 32'h48)  $display("FAIL s2_last got %h exp %h", lm, 32'h48);   else passed++;
    checks++;
    if (idxs !== 128'h0001_1011 || nv != 4) $display("FAIL s2_idx got %h/%0d exp 00011011/4", idxs, nv);
    else passed++;
  endtask

  task automatic test_s1();
    run_capture(1'b0, 5'd1, 8, 32'h0, 32'h0, 5'd0);
    checks++; if (vm !== 32'h2)  $display("FAIL s1_valid got %h exp %h", vm, 32'h2);  else passed++;
    checks++;
    if (fm !== 32'h2 || lm !== 32'h2) $display("FAIL s1_first_last got %h/%h exp 2/2", fm, lm);
    else passed++;
    checks++; if (em !== 32'h1E) $display("FAIL s1_en got %h exp %h", em, 32'h1E);  else passed++;
    checks++; if (dm !== 32'h20) $display("FAIL s1_done got %h exp %h", dm, 32'h20); else passed++;
    checks++; if (bm !== 32'h3E) $display("FAIL s1_busy got %h exp %h", bm, 32'h3E); else passed++;
  endtask

  task automatic test_stall();
    run_capture(1'b0, 5'd3, 20, 32'h180, 32'h0, 5'd0);
    checks++; if (vm !== 32'h6E3A)  $display("FAIL st_valid got %h exp %h", vm, 32'h6E3A);  else passed++;
    checks++; if (em !== 32'h1FE7E) $display("FAIL st_en got %h exp %h", em, 32'h1FE7E);   else passed++;
    checks++; if (dm !== 32'h20000) $display("FAIL st_done got %h exp %h", dm, 32'h20000); else passed++;
    checks++; if (bm !== 32'h3FFFE) $display("FAIL st_busy got %h exp %h", bm, 32'h3FFFE); else passed++;
    checks++; if (fm !== 32'h822)   $display("FAIL st_first got %h exp %h", fm, 32'h822);   else passed++;
    checks++; if (lm !== 32'h4410)  $display("FAIL st_last got %h exp %h", lm, 32'h4410);   else passed++;
    checks++;
    if (idx_at[7] !== 8'h11 || idx_at[8] !== 8'h11)
      $display("FAIL st_idx_hold got %h/%h exp 11/11", idx_at[7], idx_at[8]);
    else passed++;
    checks++;
    if (idxs !== 128'h00_01_02_10_11_12_20_21_22 || nv != 9)
      $display("FAIL st_idx_seq got %h/%0d exp 000102101112202122/9", idxs, nv);
    else passed++;
  endtask

  task automatic test_err_and_ignore();
    logic [4:0] bad [0:1];
    bad[0] = 5'd0;
    bad[1] = 5'd17;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      start1 = 1'b1;
      nwords = bad[k];
      @(negedge clk);
      checks++;
      if (err1 !== 1'b1 || busy1 !== 1'b0)
        $display("FAIL err_pulse_s%0d got err=%b busy=%b exp err=1 busy=0", bad[k], err1, busy1);
      else passed++;
      @(posedge clk); #1;
      start1 = 1'b0;
      @(negedge clk);
      checks++;
      if (err1 !== 1'b0 || busy1 !== 1'b0)
        $display("FAIL err_after_s%0d got err=%b busy=%b exp err=0 busy=0", bad[k], err1, busy1);
      else passed++;
    end
    run_capture(1'b0, 5'd2, 12, 32'h0, 32'h18, 5'd0);
    checks++; if (errm !== 32'h0) $display("FAIL busy_start_err got %h exp %h", errm, 32'h0); else passed++;
    checks++; if (dm !== 32'h200) $display("FAIL busy_start_done got %h exp %h", dm, 32'h200); else passed++;
    checks++; if (vm !== 32'h5A)  $display("FAIL busy_start_valid got %h exp %h", vm, 32'h5A); else passed++;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] o;
    logic       saw_done;
    @(posedge clk); #1;
    start1 = 1'b1;
    nwords = 5'd2;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid1 !== 1'b1 || a1 !== 4'd1) $display("FAIL rst_pre_issue got v=%b a=%h exp v=1 a=1", valid1, a1);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    o = {busy1, en1, valid1, first1, last1, done1, err1, 1'b0};
    checks++;
    if (o !== 8'h00 || a1 !== 4'h0 || b1 !== 4'h0)
      $display("FAIL rst_async got %h/%h/%h exp 00/0/0", o, a1, b1);
    else passed++;
    @(negedge clk); #2;
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done1 === 1'b1 || busy1 === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) $display("FAIL rst_no_done got %b exp %b", saw_done, 1'b0);
    else passed++;
    run_capture(1'b0, 5'd2, 12, 32'h0, 32'h0, 5'd0);
    checks++; if (vm !== 32'h5A)  $display("FAIL rst_rerun_valid got %h exp %h", vm, 32'h5A);  else passed++;
    checks++; if (em !== 32'h1FE) $display("FAIL rst_rerun_en got %h exp %h", em, 32'h1FE);   else passed++;
    checks++; if (dm !== 32'h200) $display("FAIL rst_rerun_done got %h exp %h", dm, 32'h200); else passed++;
    checks++;
    if (idxs !== 128'h0001_1011) $display("FAIL rst_rerun_idx got %h exp %h", idxs, 128'h0001_1011);
    else passed++;
  endtask

  task automatic test_back_to_back();
    run_capture(1'b1, 5'd4, 20, 32'h0, 32'h0, 5'd0);
    checks++; if (vm !== 32'h1FFFE) $display("FAIL b2b_valid got %h exp %h", vm, 32'h1FFFE); else passed++;
    checks++; if (em !== 32'h1FFFE) $display("FAIL b2b_en got %h exp %h", em, 32'h1FFFE);    else passed++;
    checks++; if (dm !== 32'h20000) $display("FAIL b2b_done got %h exp %h", dm, 32'h20000);  else passed++;
    checks++; if (fm !== 32'h2222)  $display("FAIL b2b_first got %h exp %h", fm, 32'h2222);   else passed++;
    checks++; if (lm !== 32'h11110) $display("FAIL b2b_last got %h exp %h", lm, 32'h11110);  else passed++;
    checks++;
    if (idxs !== 128'h00010203_10111213_20212223_30313233 || nv != 16)
      $display("FAIL b2b_idx got %h/%0d exp 00010203101112132021222330313233/16", idxs, nv);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_s2_nominal();
    test_s1();
    test_stall();
    test_err_and_ignore();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fios_issue_sequencer.md
# fios_issue_sequencer

Sequencer for the word-serial FIOS Montgomery multiplier datapath. It walks the outer (i) and inner (j) word loops for an operand length of `nwords` words and issues one (i, j) word-pair per cycle. It inserts a fixed bubble after each j = 0 issue so the quotient word can be computed. It drives the shared enable of the pipeline delay lines and drains the pipeline before signalling completion.

## Interface
Parameters:
- NWORDS_MAX, 16: maximum supported operand length in words.
- Q_LAT, 1: bubble cycles inserted after each j = 0 issue (quotient latency); 0 allowed.
- PIPE_DEPTH, 2: datapath/delay-line depth drained after the final issue; 0 allowed.
- Derived: IDX_W = max(1, clog2(NWORDS_MAX)); LEN_W = clog2(NWORDS_MAX+1).

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- start_i  in  1  start request; sampled only in IDLE.
- nwords_i  in  LEN_W  operand length s; sampled with start_i.
- stall_i  in  1  downstream back-pressure; freezes the sequencer and the pipeline.
- busy_o  out  1  high in every state except IDLE.
- en_o  out  1  shared enable to the datapath delay lines.
- valid_o  out  1  an (i, j) pair is issued this cycle.
- a_idx_o  out  IDX_W  inner index j (A-operand / modulus word).
- b_idx_o  out  IDX_W  outer index i (B-operand word).
- first_o  out  1  valid_o & (j == 0).
- last_o  out  1  valid_o & (j == s-1).
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse: start_i with s == 0 or s > NWORDS_MAX.

## Operation
- States: IDLE, ISSUE, QWAIT, DRAIN, DONE. Registers: state, i, j, s_q, qcnt, dcnt, fin flag.
- IDLE:
  - start_i with 1 ≤ s ≤ NWORDS_MAX → latch s_q, i = j = 0, fin = 0, go to ISSUE.
  - Out-of-range s → err_o for 1 cycle, stay in IDLE.
- ISSUE (only when !stall_i):
  - Assert valid_o with the current (i, j).
  - Advance: j == s_q-1 → j = 0, i++; otherwise j++.
  - Final pair (i = j = s_q-1) → set fin.
  - Next state:
    - j == 0 and Q_LAT > 0 → QWAIT, qcnt = Q_LAT.
    - Else if final pair → DRAIN, dcnt = PIPE_DEPTH, or DONE if PIPE_DEPTH == 0.
    - Else stay in ISSUE.
- QWAIT: qcnt decrements on unstalled cycles. At qcnt == 1 → ISSUE if !fin, else DRAIN/DONE as above.
- DRAIN: dcnt decrements on unstalled cycles. At dcnt == 1 → DONE.
- DONE: done_o = 1 for exactly 1 cycle, then IDLE.
- Output equations:
  - en_o = (ISSUE | QWAIT | DRAIN) & !stall_i.
  - valid_o = ISSUE & !stall_i.
- Stall: all registers hold, en_o = valid_o = 0. Indices remain stable on a_idx_o/b_idx_o.
- start_i while busy is ignored and does not raise err_o.
- Index registers never exceed s_q-1 during issue. They wrap to 0 after the final pair, and their value is don't-care after DONE.

## Timing
- Reset (asynchronous, immediate): state = IDLE, all counters 0. All outputs 0, including a_idx_o and b_idx_o.
- Reset mid-operation aborts with no done_o. After release, the block accepts start_i on the next edge.
- Latency, no stalls:
  - start_i sampled at edge T.
  - First valid_o (0, 0) in cycle T+1.
  - done_o in cycle T + s² + s·Q_LAT + PIPE_DEPTH + 1.
  - busy_o falls in the following cycle.
- Each stall cycle extends the total by exactly 1 cycle, in any non-IDLE/DONE state.
- stall_i has no effect in IDLE or DONE. done_o is never delayed by stall_i once DONE is reached.
- Issue order: row-major, with i outer and j inner.
- Exactly s² valid_o cycles, s first_o pulses and s last_o pulses per run.
- With s == 1: first_o and last_o are high in the same cycle.

## Test plan
- s = 2, Q_LAT = 1, PIPE_DEPTH = 2, start at T = 0, no stall → valid at cycles 1, 3, 4, 6 with (i,j) = (0,0), (0,1), (1,0), (1,1); en_o high in cycles 1–8; done_o at cycle 9.
- s = 1 → valid (0,0) with first_o = last_o = 1 at cycle 1; QWAIT at cycle 2; DRAIN at cycles 3–4; done_o at cycle 5.
- s = 3, stall_i high for 2 cycles during the issue of (1,1) → indices held, en_o = valid_o = 0; done_o at cycle 3·3 + 3 + 2 + 1 + 2 = 17.
- start_i with s = 0, then with s = 17 (NWORDS_MAX = 16) → err_o pulse each time, busy_o stays 0; start_i during a run → ignored.
- reset_i low asynchronously mid-ISSUE → all outputs 0 immediately, no done_o; restart with s = 2 → full nominal sequence.
- Q_LAT = 0, PIPE_DEPTH = 0, s = 4 → 16 back-to-back valid cycles (1–16); done_o at cycle 17.
